// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between execute and a word-wide single-port RAM.
// Handles lb/lbu/lh/lhu/lw loads with extraction/extension, sw direct writes,
// and sb/sh as read-modify-write because the RAM only has a whole-word enable.
// Handshake: a request is taken on a rising edge where req_valid_i=1 and
// req_ready_o=1 (ready is high only in IDLE); the result is a one-cycle
// rsp_valid_o pulse with rsp_dat_o/rsp_err_o, no backpressure on the response.
module mem_access_ctrl #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        ram_wen_o,
  output logic [31:0] ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic [31:0] ram_dat_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(RD_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [15:0] r_sdat;
  logic [1:0]  r_cnt;

  logic        w_accept;
  logic        w_req_err;
  logic        w_is_sw;
  logic        w_rd_last;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic f_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    bad_f3 = we ? (f3 > 3'b010) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    return bad_f3 || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  assign w_accept    = (r_state == IDLE) && req_valid_i;
  assign w_req_err   = f_err(req_we_i, req_funct3_i, req_adr_i[1:0]);
  assign w_is_sw     = req_we_i && (req_funct3_i == 3'b010);
  assign w_rd_last   = (r_state == RD_WAIT) && (r_cnt == CNT_LAST);
  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == RESP);
  assign ram_wen_o   = (r_state == WRITE);
  assign dbg_state_o = r_state;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          if (w_req_err)    w_next = RESP;
          else if (w_is_sw) w_next = WRITE;
          else              w_next = RD_WAIT;
        end
      end
      RD_WAIT: if (r_cnt == CNT_LAST) w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load extraction/extension and sub-word store merge from the read word.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = r_lane[1] ? ram_dat_i[31:16] : ram_dat_i[15:0];
    w_load  = ram_dat_i;
    w_merge = ram_dat_i;
    case (r_lane)
      2'd0: w_byte = ram_dat_i[7:0];
      2'd1: w_byte = ram_dat_i[15:8];
      2'd2: w_byte = ram_dat_i[23:16];
      default: w_byte = ram_dat_i[31:24];
    endcase
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = ram_dat_i;
    endcase
    if (r_f3[1:0] == 2'b00) begin
      case (r_lane)
        2'd0: w_merge[7:0]   = r_sdat[7:0];
        2'd1: w_merge[15:8]  = r_sdat[7:0];
        2'd2: w_merge[23:16] = r_sdat[7:0];
        default: w_merge[31:24] = r_sdat[7:0];
      endcase
    end else if (r_lane[1]) begin
      w_merge[31:16] = r_sdat;
    end else begin
      w_merge[15:0] = r_sdat;
    end
  end

  // Request latch, read-latency counter, RAM address/data and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we      <= 1'b0;
      r_f3      <= 3'b000;
      r_lane    <= 2'b00;
      r_sdat    <= 16'h0;
      r_cnt     <= 2'b00;
      ram_adr_o <= 32'h0;
      ram_dat_o <= 32'h0;
      rsp_dat_o <= 32'h0;
      rsp_err_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we      <= req_we_i;
        r_f3      <= req_funct3_i;
        r_lane    <= req_adr_i[1:0];
        r_sdat    <= req_dat_i[15:0];
        r_cnt     <= 2'b00;
        ram_adr_o <= {req_adr_i[31:2], 2'b00};
        if (w_req_err) begin
          rsp_dat_o <= 32'h0;
          rsp_err_o <= 1'b1;
        end else if (w_is_sw) begin
          ram_dat_o <= req_dat_i;
        end
      end
      if (r_state == RD_WAIT) begin
        if (!w_rd_last) begin
          r_cnt <= r_cnt + 2'd1;
        end else if (r_we) begin
          ram_dat_o <= w_merge;
        end else begin
          rsp_dat_o <= w_load;
          rsp_err_o <= 1'b0;
        end
      end
      if (r_state == WRITE) begin
        rsp_dat_o <= 32'h0;
        rsp_err_o <= 1'b0;
      end
    end
  end

endmodule
